// File: rtl/tmr_bc_counter_if.sv
// tmr_bc_counter_if: control and status bundle for the TMR bunch-crossing counter
interface tmr_bc_counter_if #(
  parameter int WIDTH = 8,
  parameter int ERRCNT_WIDTH = 8
);
  logic ClearBC;
  logic LoadBC;
  logic [WIDTH-1:0] LoadValue;
  logic Enable;
  logic [WIDTH-1:0] WrapValue;
  logic ClearError;
  logic [1:0] InjectSel;
  logic [WIDTH-1:0] InjectMask;
  logic [WIDTH-1:0] BC;
  logic Carry;
  logic Error;
  logic ErrorSticky;
  logic [ERRCNT_WIDTH-1:0] ErrorCount;
  modport master (
    output ClearBC, LoadBC, LoadValue, Enable, WrapValue, ClearError, InjectSel, InjectMask,
    input BC, Carry, Error, ErrorSticky, ErrorCount
  );
  modport slave (
    input ClearBC, LoadBC, LoadValue, Enable, WrapValue, ClearError, InjectSel, InjectMask,
    output BC, Carry, Error, ErrorSticky, ErrorCount
  );
endinterface

// File: rtl/tmr_bc_counter.sv
// tmr_bc_counter: triplicated BC counter, majority-voted and scrubbed every cycle
module tmr_bc_counter #(
  parameter int WIDTH = 8,
  parameter int ERRCNT_WIDTH = 8,
  parameter int RESET_VALUE = 0
) (
  input logic Clk,
  input logic Reset,
  tmr_bc_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VALUE);
  logic [WIDTH-1:0] copy [3];
  logic [WIDTH-1:0] vote;
  logic [WIDTH-1:0] nxt;
  logic mismatch;
  logic wrap;
  logic carry_n;
  logic [ERRCNT_WIDTH-1:0] cnt_inc;
  always_comb begin
    vote = (copy[0] & copy[1]) | (copy[1] & copy[2]) | (copy[0] & copy[2]);
    mismatch = !(copy[0] == copy[1] && copy[1] == copy[2]);
    wrap = vote >= bus.WrapValue;
    nxt = !Reset ? RV :
          bus.ClearBC ? RV :
          bus.LoadBC ? bus.LoadValue :
          bus.Enable ? (wrap ? '0 : vote + WIDTH'(1)) :
          vote;
    carry_n = Reset && !bus.ClearBC && !bus.LoadBC && bus.Enable && wrap;
    cnt_inc = &bus.ErrorCount ? bus.ErrorCount : bus.ErrorCount + ERRCNT_WIDTH'(1);
  end
  assign bus.BC = vote;
  // injection is gated by Reset so reset always leaves the copies in agreement
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 3; i++)
      copy[i] <= nxt ^ ((Reset && bus.InjectSel == 2'(i)) ? bus.InjectMask : '0);
    bus.Carry <= carry_n;
    if (!Reset) begin
      bus.Error <= 1'b0;
      bus.ErrorSticky <= 1'b0;
      bus.ErrorCount <= '0;
    end else begin
      bus.Error <= mismatch;
      bus.ErrorSticky <= mismatch ? 1'b1 : bus.ClearError ? 1'b0 : bus.ErrorSticky;
      bus.ErrorCount <= mismatch ? (bus.ClearError ? ERRCNT_WIDTH'(1) : cnt_inc) :
                        bus.ClearError ? '0 : bus.ErrorCount;
    end
  end
endmodule
